// File: rtl/game_pkg.sv
// Shared types and sizing for the memory-game symbol path.
package game_pkg;

    localparam int unsigned SYM_W     = 3;
    localparam int unsigned MAX_LEN   = 25;
    localparam int unsigned PATTERN_W = MAX_LEN * SYM_W;
    localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned NUM_LEDS  = 1 << SYM_W;

    typedef logic [SYM_W-1:0] symbol_t;

    typedef enum logic [1:0] {PB_IDLE, PB_ON, PB_GAP, PB_FIN} pb_state_t;

    function automatic symbol_t symbol_at(input logic [PATTERN_W-1:0] pattern,
                                          input logic [LEN_W-1:0]     idx);
        return pattern[SYM_W*idx +: SYM_W];
    endfunction

    function automatic logic [NUM_LEDS-1:0] one_hot(input symbol_t sym);
        logic [NUM_LEDS-1:0] v;
        v      = '0;
        v[sym] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pattern_playback_if.sv
// Handshake and data bundle between the mode FSMs / pattern register and playback.
interface pattern_playback_if;

    logic                            start;
    logic                            clr;
    logic                            reverse;
    logic [game_pkg::LEN_W-1:0]      len;
    logic [game_pkg::PATTERN_W-1:0]  pattern;
    logic [game_pkg::NUM_LEDS-1:0]   led;
    logic                            busy;
    logic                            done;
    logic [game_pkg::LEN_W-1:0]      sym_idx;

    modport master (
        output start, clr, reverse, len, pattern,
        input  led, busy, done, sym_idx
    );

    modport slave (
        input  start, clr, reverse, len, pattern,
        output led, busy, done, sym_idx
    );

endinterface

// File: rtl/playback_timer.sv
// Down-counter: loads a value, counts to zero and holds there; expired while at zero.
module playback_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/pattern_playback.sv
// Replays the stored symbol pattern as timed one-hot LED flashes separated by blanks.
module pattern_playback
    import game_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 500,
    parameter int unsigned OFF_CYCLES = 250
) (
    input logic               clock,
    input logic               rst_n,
    pattern_playback_if.slave pb
);

    localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    // Timer is loaded with N-1 so that expiry lands on the N-th cycle of the state.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    pb_state_t              state_q, state_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic                   rev_q, rev_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [NUM_LEDS-1:0]    led_q, led_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   tmr_load;
    logic [TW-1:0]          tmr_val;
    logic                   tmr_en;
    logic                   tmr_expired;
    logic [LEN_W-1:0]       len_clamped;
    logic                   last_sym;

    assign len_clamped = (pb.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pb.len;
    assign last_sym    = rev_q ? (idx_q == '0) : (idx_q == len_q - LEN_W'(1));
    assign tmr_en      = (state_q == PB_ON) || (state_q == PB_GAP);

    playback_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PB_IDLE;
            pat_q   <= '0;
            rev_q   <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rev_q   <= rev_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        rev_d    = rev_q;
        len_d    = len_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = ON_LOAD;
        if (pb.clr) begin
            state_d = PB_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                PB_IDLE: begin
                    if (pb.start) begin
                        pat_d = pb.pattern;
                        rev_d = pb.reverse;
                        len_d = len_clamped;
                        idx_d = '0;
                        if (len_clamped == '0) begin
                            state_d = PB_FIN;
                        end else begin
                            state_d  = PB_ON;
                            tmr_load = 1'b1;
                            if (pb.reverse) idx_d = len_clamped - LEN_W'(1);
                        end
                    end
                end
                PB_ON: begin
                    if (tmr_expired) begin
                        state_d  = PB_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_LOAD;
                    end
                end
                PB_GAP: begin
                    if (tmr_expired) begin
                        if (last_sym) begin
                            state_d = PB_FIN;
                        end else begin
                            state_d  = PB_ON;
                            tmr_load = 1'b1;
                            idx_d    = rev_q ? idx_q - LEN_W'(1) : idx_q + LEN_W'(1);
                        end
                    end
                end
                PB_FIN: begin
                    state_d = PB_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = PB_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next state so they register in step with it.
    always_comb begin
        led_d  = (state_d == PB_ON) ? one_hot(symbol_at(pat_d, idx_d)) : '0;
        busy_d = (state_d != PB_IDLE);
        done_d = (state_d == PB_FIN);
    end

    assign pb.led     = led_q;
    assign pb.busy    = busy_q;
    assign pb.done    = done_q;
    assign pb.sym_idx = idx_q;

endmodule

// File: tb/tb_pattern_playback.sv
// Directed bench for pattern_playback with ON_CYCLES=4, OFF_CYCLES=2.
module tb_pattern_playback;
    import game_pkg::*;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    pattern_playback_if pb_if ();

    pattern_playback #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .pb    (pb_if)
    );

    typedef struct {
        logic                 start;
        logic                 reverse;
        logic [LEN_W-1:0]     len;
        logic [PATTERN_W-1:0] pattern;
        logic [7:0]           led;
        logic                 busy;
        logic                 done;
        logic [LEN_W-1:0]     idx;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [PATTERN_W-1:0] pat_a;
    logic [PATTERN_W-1:0] pat_b;
    logic [PATTERN_W-1:0] pat_x;

    task automatic add(input int n, input logic st, input logic rv, input logic [LEN_W-1:0] ln,
                       input logic [PATTERN_W-1:0] pat, input logic [7:0] led,
                       input logic busy, input logic done, input logic [LEN_W-1:0] idx);
        vec_t v;
        v.start = st; v.reverse = rv; v.len = ln; v.pattern = pat;
        v.led = led; v.busy = busy; v.done = done; v.idx = idx;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic rv, input logic [LEN_W-1:0] ln,
                         input logic [PATTERN_W-1:0] pat);
        pb_if.start   = st;
        pb_if.reverse = rv;
        pb_if.len     = ln;
        pb_if.pattern = pat;
    endtask

    task automatic check(input string name, input logic [7:0] e_led, input logic e_busy,
                         input logic e_done, input logic [LEN_W-1:0] e_idx);
        n_vec++;
        if (pb_if.led !== e_led || pb_if.busy !== e_busy || pb_if.done !== e_done ||
            pb_if.sym_idx !== e_idx) begin
            n_err++;
            $display("FAIL %s: got led=%h busy=%b done=%b idx=%0d, want led=%h busy=%b done=%b idx=%0d",
                     name, pb_if.led, pb_if.busy, pb_if.done, pb_if.sym_idx,
                     e_led, e_busy, e_done, e_idx);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; each vector spans exactly one clock.
    task automatic run_vectors(input string name);
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].reverse, vecs[i].len, vecs[i].pattern);
            @(negedge clock);
            check($sformatf("%s[%0d]", name, i), vecs[i].led, vecs[i].busy, vecs[i].done,
                  vecs[i].idx);
        end
        vecs.delete();
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   found;
        int   seen;
        int   flashes;
        int   bad;
        int   done_cyc;
        logic [7:0] prev;
        logic [7:0] e_led;

        pat_a = '0;
        pat_a[2:0] = 3'd5;
        pat_a[5:3] = 3'd2;
        pat_a[8:6] = 3'd7;
        pat_b = '0;
        for (int i = 0; i < 25; i++) pat_b[3*i +: 3] = 3'(i % 8);
        pat_x = '1;

        rst_n = 1'b0;
        pb_if.clr = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        check("reset_low", 8'h00, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;
        @(negedge clock);
        check("reset_idle", 8'h00, 1'b0, 1'b0, 5'd0);

        // Forward play; inputs scrambled after start and a start pulse while busy.
        add(1, 1, 0, 5'd3, pat_a, 8'h20, 1, 0, 5'd0);
        add(3, 0, 1, 5'd1, pat_x, 8'h20, 1, 0, 5'd0);
        add(2, 1, 1, 5'd1, pat_x, 8'h00, 1, 0, 5'd0);
        add(4, 0, 0, 5'd3, pat_a, 8'h04, 1, 0, 5'd1);
        add(2, 0, 0, 5'd3, pat_a, 8'h00, 1, 0, 5'd1);
        add(4, 0, 0, 5'd3, pat_a, 8'h80, 1, 0, 5'd2);
        add(2, 0, 0, 5'd3, pat_a, 8'h00, 1, 0, 5'd2);
        add(1, 0, 0, 5'd3, pat_a, 8'h00, 1, 1, 5'd2);
        add(1, 0, 0, 5'd3, pat_a, 8'h00, 0, 0, 5'd0);
        run_vectors("fwd");

        add(1, 1, 1, 5'd3, pat_a, 8'h80, 1, 0, 5'd2);
        add(3, 0, 1, 5'd3, pat_a, 8'h80, 1, 0, 5'd2);
        add(2, 0, 1, 5'd3, pat_a, 8'h00, 1, 0, 5'd2);
        add(4, 0, 1, 5'd3, pat_a, 8'h04, 1, 0, 5'd1);
        add(2, 0, 1, 5'd3, pat_a, 8'h00, 1, 0, 5'd1);
        add(4, 0, 1, 5'd3, pat_a, 8'h20, 1, 0, 5'd0);
        add(2, 0, 1, 5'd3, pat_a, 8'h00, 1, 0, 5'd0);
        add(1, 0, 1, 5'd3, pat_a, 8'h00, 1, 1, 5'd0);
        add(1, 0, 1, 5'd3, pat_a, 8'h00, 0, 0, 5'd0);
        run_vectors("rev");

        // Zero length, with start held so a second run follows the FIN cycle.
        add(1, 1, 0, 5'd0, pat_a, 8'h00, 1, 1, 5'd0);
        add(1, 1, 0, 5'd0, pat_a, 8'h00, 0, 0, 5'd0);
        add(1, 1, 0, 5'd0, pat_a, 8'h00, 1, 1, 5'd0);
        add(3, 0, 0, 5'd0, pat_a, 8'h00, 0, 0, 5'd0);
        run_vectors("zero");

        // Abort mid-ON of symbol 1; clr also wins over a simultaneous start.
        drive(1'b1, 1'b0, 5'd3, pat_a);
        @(negedge clock);
        pb_if.start = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clock);
            if (pb_if.sym_idx == 5'd1 && pb_if.led != 8'h00) found = 1;
        end
        check_int("abort_reach_sym1", found, 1);
        @(negedge clock);
        pb_if.clr   = 1'b1;
        pb_if.start = 1'b1;
        @(negedge clock);
        check("abort_now", 8'h00, 1'b0, 1'b0, 5'd0);
        pb_if.clr   = 1'b0;
        pb_if.start = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (pb_if.done || pb_if.busy || pb_if.led != 8'h00) seen++;
        end
        check_int("abort_quiet", seen, 0);

        // Clamp: len=31 plays 25 symbols, symbol i = i%8.
        drive(1'b1, 1'b0, 5'd31, pat_b);
        flashes = 0; bad = 0; done_cyc = -1; prev = 8'h00;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == 1) pb_if.start = 1'b0;
            if (pb_if.led != 8'h00 && prev == 8'h00) begin
                e_led = 8'd1 << (flashes % 8);
                if (pb_if.led != e_led) bad++;
                flashes++;
            end
            prev = pb_if.led;
            if (pb_if.done) begin
                done_cyc = c;
                break;
            end
        end
        check_int("clamp_flashes", flashes, 25);
        check_int("clamp_done_cycle", done_cyc, 1 + 25 * 6);
        check_int("clamp_led_order", bad, 0);
        @(negedge clock);
        check("clamp_idle", 8'h00, 1'b0, 1'b0, 5'd0);

        // Async reset during the first GAP, then replay from index 0.
        drive(1'b1, 1'b0, 5'd3, pat_a);
        @(negedge clock);
        pb_if.start = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clock);
            if (pb_if.busy && pb_if.led == 8'h00) found = 1;
        end
        check_int("arst_reach_gap", found, 1);
        #2 rst_n = 1'b0;
        #1 check("arst_immediate", 8'h00, 1'b0, 1'b0, 5'd0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        drive(1'b1, 1'b0, 5'd3, pat_a);
        @(negedge clock);
        pb_if.start = 1'b0;
        check("arst_restart", 8'h20, 1'b1, 1'b0, 5'd0);
        done_cyc = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clock);
            if (pb_if.done) begin
                done_cyc = c;
                break;
            end
        end
        check_int("arst_done_cycle", done_cyc, 19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
